// File: rtl/asm_weight_precode_ctrl_pkg.sv
// asm_weight_precode_ctrl_pkg: shared state encoding and code-field packing constants
package asm_weight_precode_ctrl_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;
  localparam int CODE_W = 2;
  localparam int NIB_W  = 4;
  function automatic int code_width(input int width);
    return CODE_W * (width / NIB_W);
  endfunction
endpackage

// File: rtl/asm_weight_precode_ctrl_control_unit.sv
// asm_weight_precode_ctrl_control_unit: nibble = alphabet << sl, alphabet = 2*sel+1 (odd part mod 8)
module asm_weight_precode_ctrl_control_unit
  import asm_weight_precode_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0]  nib,
  output logic [CODE_W-1:0] sl,
  output logic [CODE_W-1:0] sel
);
  always_comb begin
    sl  = nib[0] ? 2'd0 : nib[1] ? 2'd1 : nib[2] ? 2'd2 : nib[3] ? 2'd3 : 2'd0;
    sel = 2'(nib >> ({1'b0, sl} + 3'd1));
  end
endmodule

// File: rtl/asm_weight_precode_ctrl.sv
// asm_weight_precode_ctrl: buffers a tile of pre-coded weights and drains it over a valid/ready port
module asm_weight_precode_ctrl
  import asm_weight_precode_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int NIBBLES = WIDTH / NIB_W,
  localparam int CW = code_width(WIDTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [WIDTH-1:0] w_data,
  input  logic          start,
  input  logic          repeat_en,
  input  logic          abort,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [CW-1:0] o_sl,
  output logic [CW-1:0] o_sel,
  output logic [AW-1:0] o_idx,
  output logic          o_last,
  output logic          busy,
  output logic          done
);
  logic [1:0]    state;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] code_sl;
  logic [CW-1:0] code_sel;
  logic [CW-1:0] buf_sl  [DEPTH];
  logic [CW-1:0] buf_sel [DEPTH];
  logic          wr;
  logic          hs;
  for (genvar i = 0; i < NIBBLES; i++) begin : g_cu
    asm_weight_precode_ctrl_control_unit u_cu (
      .nib (w_data[NIB_W*i +: NIB_W]),
      .sl  (code_sl[CODE_W*i +: CODE_W]),
      .sel (code_sel[CODE_W*i +: CODE_W])
    );
  end
  always_comb begin
    w_ready = (state == ST_IDLE) || (state == ST_FILL);
    o_valid = state == ST_DRAIN;
    o_sl    = o_valid ? buf_sl[rd_ptr] : '0;
    o_sel   = o_valid ? buf_sel[rd_ptr] : '0;
    o_idx   = o_valid ? rd_ptr : '0;
    o_last  = o_valid && (rd_ptr == AW'(DEPTH - 1));
    busy    = state != ST_IDLE;
    wr      = w_valid && w_ready;
    hs      = o_valid && o_ready;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      wr_cnt <= '0;
      rd_ptr <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state  <= ST_IDLE;
        wr_cnt <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr) begin
          wr_cnt <= wr_cnt + 1'b1;
          state  <= (wr_cnt == AW'(DEPTH - 1)) ? ST_FULL : ST_FILL;
        end
        if (state == ST_FULL && start) begin
          state  <= ST_DRAIN;
          rd_ptr <= '0;
        end
        if (hs) begin
          rd_ptr <= rd_ptr + 1'b1;
          if (o_last) begin
            done   <= 1'b1;
            state  <= repeat_en ? ST_FULL : ST_IDLE;
            wr_cnt <= '0;
          end
        end
      end
    end
  end
  // Buffer is never visible outside DRAIN, so it carries no reset
  always_ff @(posedge clk) begin
    if (wr && !abort) begin
      buf_sl[wr_cnt]  <= code_sl;
      buf_sel[wr_cnt] <= code_sel;
    end
  end
endmodule

// File: tb/tb_asm_weight_precode_ctrl.sv
// tb_asm_weight_precode_ctrl: table vectors, directed corner sequences and randomized tiles vs a reference model
module tb_asm_weight_precode_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic w_valid = 1'b0, w_ready, start = 1'b0, repeat_en = 1'b0, abort = 1'b0;
  logic o_valid, o_ready = 1'b0, o_last, busy, done;
  logic [WIDTH-1:0] w_data = '0;
  logic [CW-1:0] o_sl, o_sel;
  logic [AW-1:0] o_idx;

  asm_weight_precode_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .start(start), .repeat_en(repeat_en), .abort(abort), .o_valid(o_valid), .o_ready(o_ready),
    .o_sl(o_sl), .o_sel(o_sel), .o_idx(o_idx), .o_last(o_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [15:0] sl;
    logic [15:0] sel;
  } vec_t;

  vec_t vecs [8];
  logic [31:0] tile [DEPTH];
  int checks = 0;
  int passes = 0;

  // Each nonzero nibble is an odd alphabet shifted left; sl = shift, sel = (alphabet/2) mod 4
  function automatic logic [31:0] ref_code(input logic [31:0] w);
    logic [15:0] sl = '0;
    logic [15:0] sel = '0;
    for (int i = 0; i < 8; i++) begin
      int v;
      int t;
      v = int'((w >> (4 * i)) & 32'hF);
      t = 0;
      if (v != 0) begin
        while (v % 2 == 0) begin
          v = v / 2;
          t++;
        end
        sl  = sl | 16'(t << (2 * i));
        sel = sel | 16'(((v / 2) % 4) << (2 * i));
      end
    end
    return {sl, sel};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_w_ready"}, 64'(w_ready), 64'(1));
    chk({tag, "_o_valid"}, 64'(o_valid), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(exp_done));
    chk({tag, "_outs_zero"}, {29'd0, o_sl, o_sel, o_idx, o_last}, 64'(0));
  endtask

  task automatic fill_tile(input bit gaps);
    int n = 0;
    int guard = 0;
    while (n < DEPTH && guard < 200) begin
      w_valid = gaps ? 1'($urandom % 2) : 1'b1;
      w_data = tile[n];
      start = gaps ? ($urandom % 4 == 0) : 1'b0;
      chk("fill_w_ready", 64'(w_ready), 64'(1));
      chk("fill_o_valid", 64'(o_valid), 64'(0));
      cyc();
      if (w_valid) n++;
      guard++;
    end
    w_valid = 1'b0;
    start = 1'b0;
    if (guard >= 200) chk("fill_timeout", 64'(n), 64'(DEPTH));
    chk("full_w_ready", 64'(w_ready), 64'(0));
    chk("full_busy", 64'(busy), 64'(1));
    chk("full_o_valid", 64'(o_valid), 64'(0));
  endtask

  task automatic drain_tile(input bit rnd, input bit rep);
    int idx = 0;
    int guard = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat_en = rep;
    while (idx < DEPTH && guard < 200) begin
      o_ready = rnd ? 1'($urandom % 2) : 1'b1;
      chk("drain_o_valid", 64'(o_valid), 64'(1));
      chk("drain_idx", 64'(o_idx), 64'(idx));
      chk("drain_code", {o_sl, o_sel}, 64'(ref_code(tile[idx])));
      chk("drain_last", 64'(o_last), 64'(idx == DEPTH - 1));
      chk("drain_w_ready", 64'(w_ready), 64'(0));
      chk("drain_done", 64'(done), 64'(0));
      cyc();
      if (o_ready) idx++;
      guard++;
    end
    o_ready = 1'b0;
    repeat_en = 1'b0;
    if (guard >= 200) chk("drain_timeout", 64'(idx), 64'(DEPTH));
    chk("end_done", 64'(done), 64'(1));
    chk("end_busy", 64'(busy), 64'(rep));
    chk("end_w_ready", 64'(w_ready), 64'(!rep));
    chk("end_o_valid", 64'(o_valid), 64'(0));
  endtask

  task automatic rand_tile();
    for (int i = 0; i < DEPTH; i++) tile[i] = $urandom;
  endtask

  initial begin
    vecs[0] = '{32'hFFFFFFFF, 16'h0000, 16'hFFFF};
    vecs[1] = '{32'h00000000, 16'h0000, 16'h0000};
    vecs[2] = '{32'h88888888, 16'hFFFF, 16'h0000};
    vecs[3] = '{32'h66666666, 16'h5555, 16'h5555};
    vecs[4] = '{32'hCCCCCCCC, 16'hAAAA, 16'h5555};
    vecs[5] = '{32'h12345678, 16'h1213, 16'h049C};
    vecs[6] = '{32'hAAAAAAAA, 16'h5555, 16'hAAAA};
    vecs[7] = '{32'hBBBBBBBB, 16'h0000, 16'h5555};

    #12;
    chk_idle("reset", 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk_idle("post_reset", 1'b0);

    // Table tile; start after 5 writes must be ignored
    for (int i = 0; i < DEPTH; i++) tile[i] = vecs[i].w;
    for (int i = 0; i < 5; i++) begin
      w_valid = 1'b1;
      w_data = vecs[i].w;
      cyc();
    end
    w_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("early_start_busy", 64'(busy), 64'(1));
    chk("early_start_o_valid", 64'(o_valid), 64'(0));
    chk("early_start_w_ready", 64'(w_ready), 64'(1));
    cyc();
    chk("early_start_not_latched", 64'(o_valid), 64'(0));
    for (int i = 5; i < DEPTH; i++) begin
      w_valid = 1'b1;
      w_data = vecs[i].w;
      cyc();
    end
    w_valid = 1'b0;
    chk("tbl_full_w_ready", 64'(w_ready), 64'(0));
    start = 1'b1;
    cyc();
    start = 1'b0;
    o_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("tbl_idx", 64'(o_idx), 64'(i));
      chk("tbl_sl", 64'(o_sl), 64'(vecs[i].sl));
      chk("tbl_sel", 64'(o_sel), 64'(vecs[i].sel));
      chk("tbl_last", 64'(o_last), 64'(i == DEPTH - 1));
      chk("tbl_done", 64'(done), 64'(0));
      cyc();
    end
    o_ready = 1'b0;
    chk_idle("tbl_end", 1'b1);
    cyc();
    chk("tbl_done_one_cycle", 64'(done), 64'(0));

    // Stalled drain with random o_ready
    rand_tile();
    fill_tile(1'b1);
    drain_tile(1'b1, 1'b0);
    cyc();

    // Repeat: replay identical tile without refilling
    rand_tile();
    fill_tile(1'b0);
    drain_tile(1'b0, 1'b1);
    drain_tile(1'b1, 1'b0);
    cyc();

    // Abort at idx 3
    rand_tile();
    fill_tile(1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    o_ready = 1'b1;
    repeat (3) cyc();
    chk("abort_at_idx3", 64'(o_idx), 64'(3));
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    o_ready = 1'b0;
    chk_idle("abort", 1'b0);
    cyc();
    chk("abort_no_done", 64'(done), 64'(0));
    rand_tile();
    fill_tile(1'b0);
    drain_tile(1'b0, 1'b0);
    cyc();

    // Reset mid-FILL
    for (int i = 0; i < 3; i++) begin
      w_valid = 1'b1;
      w_data = $urandom;
      cyc();
    end
    w_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("rst_mid_fill", 1'b0);
    cyc();
    rst_n = 1'b1;
    rand_tile();
    fill_tile(1'b0);
    drain_tile(1'b1, 1'b0);
    cyc();

    // Reset mid-DRAIN
    rand_tile();
    fill_tile(1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    o_ready = 1'b1;
    repeat (2) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("rst_mid_drain", 1'b0);
    o_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
    rand_tile();
    fill_tile(1'b1);
    drain_tile(1'b0, 1'b0);
    cyc();

    // Randomized tiles
    for (int k = 0; k < 6; k++) begin
      bit rep;
      rep = 1'($urandom % 2);
      rand_tile();
      fill_tile(1'b1);
      drain_tile(1'b1, rep);
      if (rep) drain_tile(1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) cyc();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
